pvr_tex_fetch: RTL

PVR_TEX_FETCH -- requirements
Module: pvr_tex_fetch

---
 rtl/pvr_tex_pkg.sv | 27 ++
 rtl/pvr_texel_extract.sv | 24 ++
 rtl/pvr_tex_fetch.sv | 104 ++++++++++
 3 files changed

// File: rtl/pvr_tex_pkg.sv
// Shared encodings for the texel fetch path: texture formats, FSM states,
// and the per-request texel select fields carried through a transaction.
package pvr_tex_pkg;

  typedef enum logic [1:0] {
    FMT_4BPP  = 2'd0,
    FMT_8BPP  = 2'd1,
    FMT_16BPP = 2'd2,
    FMT_RSVD  = 2'd3
  } tex_fmt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    tex_fmt_e   fmt;
    logic       nibble;
    logic [2:0] lo;
  } texel_sel_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pvr_texel_extract.sv
// Combinational texel extraction from one 64-bit VRAM word.
module pvr_texel_extract
  import pvr_tex_pkg::*;
(
  input  logic [63:0] word,
  input  texel_sel_t  sel,
  output logic [15:0] texel
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{sel.lo, 3'b000} +: 8];
    half_v = word[{sel.lo[2:1], 4'b0000} +: 16];
    texel  = half_v;
    case (sel.fmt)
      FMT_4BPP: texel = {12'h000, sel.nibble ? byte_v[7:4] : byte_v[3:0]};
      FMT_8BPP: texel = {8'h00, byte_v};
      default:  texel = half_v;
    endcase
  end

endmodule

// File: rtl/pvr_tex_fetch.sv
// Texel fetch front-end: one-word local buffer in front of the word cache,
// single outstanding miss, one texel per cycle on back-to-back buffer hits.
module pvr_tex_fetch
  import pvr_tex_pkg::*;
#(
  parameter int ADDR_W = 29
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tex_req,
  input  logic [ADDR_W+2:0] tex_byte_addr,
  input  logic [1:0]        tex_fmt,
  input  logic              tex_nibble,
  input  logic              tex_inval,
  output logic              tex_busy,
  output logic              texel_valid,
  output logic [15:0]       texel_data,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_rd,
  input  logic              cache_valid,
  input  logic [63:0]       cache_data,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  fetch_state_e      state;
  logic [63:0]       buf_word;
  logic [ADDR_W-1:0] buf_addr;
  logic              buf_vld;
  logic              inval_pend;
  texel_sel_t        req_sel;
  texel_sel_t        live_sel;
  texel_sel_t        ext_sel;
  logic [63:0]       ext_word;
  logic [15:0]       ext_texel;
  logic [ADDR_W-1:0] req_word;
  logic              buf_hit;

  assign req_word = tex_byte_addr[ADDR_W+2:3];
  assign live_sel = '{fmt: tex_fmt_e'(tex_fmt), nibble: tex_nibble, lo: tex_byte_addr[2:0]};
  assign buf_hit  = buf_vld && (req_word == buf_addr) && !tex_inval;
  assign tex_busy = (state == ST_WAIT);

  // Hits extract from the buffer with live request fields; fills extract
  // straight from the returning cache word with the captured fields.
  assign ext_word = tex_busy ? cache_data : buf_word;
  assign ext_sel  = tex_busy ? req_sel : live_sel;

  pvr_texel_extract u_extract (
    .word  (ext_word),
    .sel   (ext_sel),
    .texel (ext_texel)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      buf_vld     <= 1'b0;
      inval_pend  <= 1'b0;
      cache_rd    <= 1'b0;
      texel_valid <= 1'b0;
      texel_data  <= '0;
      cache_addr  <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      cache_rd    <= 1'b0;
      texel_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tex_inval) buf_vld <= 1'b0;
          if (tex_req) begin
            req_sel <= live_sel;
            if (buf_hit) begin
              texel_valid <= 1'b1;
              texel_data  <= ext_texel;
              hit_cnt     <= sat_inc16(hit_cnt);
            end else begin
              cache_rd   <= 1'b1;
              cache_addr <= req_word;
              miss_cnt   <= sat_inc16(miss_cnt);
              inval_pend <= 1'b0;
              state      <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (tex_inval) inval_pend <= 1'b1;
          if (cache_valid) begin
            buf_word    <= cache_data;
            buf_addr    <= cache_addr;
            // VRAM was written while the read was in flight: data may be stale
            buf_vld     <= !(inval_pend || tex_inval);
            texel_valid <= 1'b1;
            texel_data  <= ext_texel;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
